sobel_scan_sched: RTL
=====================

SOBEL_SCAN_SCHED -- requirements
Module: sobel_scan_sched

Interface
REQ-001 SHALL have parameter IMG_W, default 8, meaning image width in pixels (minimum 3).
REQ-002 SHALL have parameter IMG_H, default 8, meaning image height in pixels (minimum 3).
REQ-003 SHALL have parameter ADDR_W, default 16, meaning read address width.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, reset; it is synchronous and active-high.
REQ-006 SHALL have port start_i, input, 1, a one-cycle pulse that starts a frame.
REQ-007 SHALL have port mem_rd_req_o, output, 1, a one-cycle read request.
REQ-008 SHALL have port mem_rd_addr_o, output, ADDR_W, the read address, valid with mem_rd_req_o.
REQ-009 SHALL have ports mem_rd_valid_i (input, 1) and mem_rd_data_i (input, PIXEL_WIDTH_OUT), the read return.
REQ-010 SHALL have ports start_sobel_o (output, 1), px_rdy_o (output, 1) and px_o (output, PIXEL_WIDTH_OUT), the window-engine feed.
REQ-011 SHALL have ports sobel_rdy_i (input, 1) and sobel_px_i (input, PIXEL_WIDTH_OUT), the engine result.
REQ-012 SHALL have ports out_valid_o (output, 1), out_px_o (output, PIXEL_WIDTH_OUT), busy_o (output, 1), frame_done_o (output, 1) and err_o (output, 1).

Function
REQ-013 SHALL use the FSM states IDLE, ISSUE, WAIT_RD, PUSH, WAIT_RES, GAP and DONE.
REQ-014 SHALL scan vertical strips at column c = 0..IMG_W-3, left to right.
REQ-015 Within each strip, SHALL process windows at top row r = 0..IMG_H-3, top to bottom.
REQ-016 SHALL form each read address as row*IMG_W+col, truncated to ADDR_W bits.
REQ-017 For the first window of a strip, SHALL read 9 pixels in row-major order: (r,c), (r,c+1), (r,c+2), (r+1,c), ..., (r+2,c+2).
REQ-018 For each later window of a strip, SHALL read only the 3 pixels (r+2,c..c+2).
REQ-019 SHALL keep at most one read outstanding; ISSUE asserts mem_rd_req_o for exactly one cycle, then moves to WAIT_RD.
REQ-020 SHALL ignore mem_rd_valid_i outside WAIT_RD.
REQ-021 On mem_rd_valid_i in WAIT_RD, SHALL register the data, then pulse px_rdy_o for one cycle in PUSH with px_o holding that data.
REQ-022 SHALL hold start_sobel_o high from the first ISSUE of a strip until that strip's last result is received.
REQ-023 SHALL hold start_sobel_o low for exactly 2 cycles in GAP between strips.
REQ-024 After the last push of each window (9th or 3rd), SHALL enter WAIT_RES and issue no reads until sobel_rdy_i is seen.
REQ-025 On sobel_rdy_i in WAIT_RES, SHALL pulse out_valid_o on the next cycle, with out_px_o equal to the registered sobel_px_i.
REQ-026 SHALL treat sobel_rdy_i outside WAIT_RES as a protocol error: err_o set, sticky until reset.
REQ-027 SHALL produce exactly (IMG_W-2)*(IMG_H-2) results per frame.
REQ-028 After the final result, SHALL go to DONE, pulse frame_done_o for one cycle, then return to IDLE.
REQ-029 SHALL drive busy_o high in every state except IDLE.
REQ-030 SHALL ignore start_i while busy_o is high.
REQ-031 SHALL accept a start_i in the same cycle frame_done_o is high.
REQ-032 SHALL size the row and column counters to clog2(IMG_H) and clog2(IMG_W); they shall not wrap within a frame.

Reset
REQ-033 While reset_i is high at a clock edge, SHALL go to IDLE and clear all counters.
REQ-034 On reset, SHALL clear every output to 0, including err_o.
REQ-035 Reset in mid-frame SHALL abandon the frame with no further reads, pushes or results.
REQ-036 SHALL ignore an in-flight mem_rd_valid_i that arrives after reset.

Configuration
REQ-037 With SOBEL_SCHED_TIMEOUT_EN defined, an 8-bit watchdog SHALL count the cycles spent in WAIT_RD or WAIT_RES.
REQ-038 With SOBEL_SCHED_TIMEOUT_EN defined, the watchdog SHALL set err_o, drop start_sobel_o and return to IDLE at count 255, with no frame_done_o.
REQ-039 Without SOBEL_SCHED_TIMEOUT_EN, SHALL wait indefinitely; err_o reports only REQ-026.

Structure
REQ-040 The state enum, PIXEL_WIDTH_OUT and the watchdog limit constant SHALL live in the shared package sobel_sched_pkg.
REQ-041 Row/column stepping and the address multiply SHALL be a sub-module sobel_addr_gen, with inputs step, strip_next and clear, and outputs addr, last_in_window, last_window and last_strip.

Verification
REQ-042 Address order: IMG_W=4, IMG_H=4, memory returns in 1 cycle.
  -> Read addresses 0,1,2,4,5,6,8,9,10,12,13,14, then GAP, then 1,2,3,5,6,7,9,10,11,13,14,15.
  -> 4 out_valid_o pulses, 1 frame_done_o.
REQ-043 Ordering: model engine returns sobel_px_i = 8'hA5 five cycles after each window.
  -> out_px_o = 8'hA5, one cycle after each sobel_rdy_i.
  -> No mem_rd_req_o between the last push of a window and sobel_rdy_i.
REQ-044 Reset mid-frame: reset_i high for 1 cycle after the 5th read.
  -> busy_o=0 and all outputs 0 on the next cycle.
  -> A later start_i yields address 0 first.
REQ-045 Stray result: sobel_rdy_i pulsed in IDLE -> err_o=1, held until reset_i.
REQ-046 Timeout, macro defined: mem_rd_valid_i never returned -> err_o=1 and state IDLE 255 cycles after the request.
  -> Macro undefined: busy_o stays 1.
REQ-047 Start while busy: start_i re-pulsed mid-frame -> read sequence unchanged, exactly 1 frame_done_o.

Source files
------------

// File: rtl/sobel_sched_pkg.sv
// Shared types and constants for the Sobel scan scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: scheduler FSM state enum, pixel width, watchdog limit used when
// SOBEL_SCHED_TIMEOUT_EN is defined.
package sobel_sched_pkg;

    localparam int         PIXEL_WIDTH_OUT = 8;
    localparam logic [7:0] WDOG_LIMIT      = 8'd255;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        PUSH,
        WAIT_RES,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/sobel_scan_sched_if.sv
// Bundles the scheduler's memory-read and window-engine signals.
// Latency: n/a (wiring only).
// Backpressure: none; one read outstanding, the engine replies with sobel_rdy_i.
// master = scheduler side, slave = memory/engine side.
interface sobel_scan_sched_if #(
    parameter int ADDR_W = 16
);
    import sobel_sched_pkg::*;

    logic                       mem_rd_req_o;
    logic [ADDR_W-1:0]          mem_rd_addr_o;
    logic                       mem_rd_valid_i;
    logic [PIXEL_WIDTH_OUT-1:0] mem_rd_data_i;
    logic                       start_sobel_o;
    logic                       px_rdy_o;
    logic [PIXEL_WIDTH_OUT-1:0] px_o;
    logic                       sobel_rdy_i;
    logic [PIXEL_WIDTH_OUT-1:0] sobel_px_i;

    modport master (
        output mem_rd_req_o, mem_rd_addr_o, start_sobel_o, px_rdy_o, px_o,
        input  mem_rd_valid_i, mem_rd_data_i, sobel_rdy_i, sobel_px_i
    );

    modport slave (
        input  mem_rd_req_o, mem_rd_addr_o, start_sobel_o, px_rdy_o, px_o,
        output mem_rd_valid_i, mem_rd_data_i, sobel_rdy_i, sobel_px_i
    );

endinterface

// File: rtl/sobel_addr_gen.sv
// Walks strip column, window top row and pixel position; forms row*IMG_W+col.
// Latency: addr is combinational from the counters; counters move one clock after step/strip_next/clear.
// Backpressure: counters hold whenever no control input is asserted.
// Ports: clk_i; step (next pixel, or next window when at the window's last pixel),
// strip_next (next strip), clear (restart frame); addr, last_in_window, last_window, last_strip.
module sobel_addr_gen #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              step,
    input  logic              strip_next,
    input  logic              clear,
    output logic [ADDR_W-1:0] addr,
    output logic              last_in_window,
    output logic              last_window,
    output logic              last_strip
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    logic [CW-1:0] col_q, col_d;   // strip's left column
    logic [RW-1:0] win_q, win_d;   // window's top row
    logic [RW-1:0] row_q, row_d;   // row of the pixel being read
    logic [1:0]    off_q, off_d;   // column offset inside the window
    logic [31:0]   addr_full;

    assign last_in_window = (off_q == 2'd2) && (int'(row_q) == int'(win_q) + 2);
    assign last_window    = (int'(win_q) == IMG_H - 3);
    assign last_strip     = (int'(col_q) == IMG_W - 3);

    assign addr_full = 32'(row_q) * 32'(IMG_W) + 32'(col_q) + 32'(off_q);
    assign addr      = addr_full[ADDR_W-1:0];

    always_comb begin
        col_d = col_q;
        win_d = win_q;
        row_d = row_q;
        off_d = off_q;
        if (clear) begin
            col_d = '0;
            win_d = '0;
            row_d = '0;
            off_d = '0;
        end else if (strip_next) begin
            col_d = col_q + CW'(1);
            win_d = '0;
            row_d = '0;
            off_d = '0;
        end else if (step) begin
            if (off_q != 2'd2) begin
                off_d = off_q + 2'd1;
            end else begin
                off_d = '0;
                if (last_in_window) begin
                    // Later windows only fetch their new bottom row.
                    win_d = win_q + RW'(1);
                    row_d = win_q + RW'(3);
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        col_q <= col_d;
        win_q <= win_d;
        row_q <= row_d;
        off_q <= off_d;
    end

endmodule

// File: rtl/sobel_scan_sched.sv
// Schedules 3x3 Sobel window reads strip by strip and forwards engine results.
// Latency: one pixel push per read return + 1 cycle; result out 1 cycle after sobel_rdy_i.
// Backpressure: one read outstanding; stalls in WAIT_RES until the engine answers.
// Ports: clk_i, reset_i (sync, active-high), start_i; bus (memory + engine, master);
// out_valid_o/out_px_o results, busy_o, frame_done_o, err_o (sticky).
// Optional: SOBEL_SCHED_TIMEOUT_EN adds an 8-bit watchdog on WAIT_RD/WAIT_RES.
module sobel_scan_sched
    import sobel_sched_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    sobel_scan_sched_if.master         bus,
    output logic                       out_valid_o,
    output logic [PIXEL_WIDTH_OUT-1:0] out_px_o,
    output logic                       busy_o,
    output logic                       frame_done_o,
    output logic                       err_o
);
    state_t                     state_q, state_d;
    logic                       gap_q, gap_d;
    logic [PIXEL_WIDTH_OUT-1:0] px_q, px_d;
    logic [PIXEL_WIDTH_OUT-1:0] out_px_q, out_px_d;
    logic                       out_valid_q, out_valid_d;
    logic                       err_q, err_d;
    logic                       step, strip_next, clear;
    logic [ADDR_W-1:0]          addr;
    logic                       last_in_window, last_window, last_strip;
`ifdef SOBEL_SCHED_TIMEOUT_EN
    logic [7:0]                 wdog_q, wdog_d;
`endif

    sobel_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i          (clk_i),
        .step           (step),
        .strip_next     (strip_next),
        .clear          (clear),
        .addr           (addr),
        .last_in_window (last_in_window),
        .last_window    (last_window),
        .last_strip     (last_strip)
    );

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        px_d        = px_q;
        out_px_d    = out_px_q;
        out_valid_d = 1'b0;
        err_d       = err_q;
        step        = 1'b0;
        strip_next  = 1'b0;
        clear       = 1'b0;

        if (bus.sobel_rdy_i && (state_q != WAIT_RES)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                clear = 1'b1;
                if (start_i) state_d = ISSUE;
            end
            ISSUE: state_d = WAIT_RD;
            WAIT_RD: begin
                if (bus.mem_rd_valid_i) begin
                    px_d    = bus.mem_rd_data_i;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                // The counters stay on the window's last pixel until the result
                // returns, so last_window still describes this window in WAIT_RES.
                if (last_in_window) begin
                    state_d = WAIT_RES;
                end else begin
                    step    = 1'b1;
                    state_d = ISSUE;
                end
            end
            WAIT_RES: begin
                if (bus.sobel_rdy_i) begin
                    out_valid_d = 1'b1;
                    out_px_d    = bus.sobel_px_i;
                    if (!last_window) begin
                        step    = 1'b1;
                        state_d = ISSUE;
                    end else if (!last_strip) begin
                        strip_next = 1'b1;
                        gap_d      = 1'b0;
                        state_d    = GAP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            GAP: begin
                // Two cycles with start_sobel_o low so the engine sees a new strip.
                gap_d = 1'b1;
                if (gap_q) state_d = ISSUE;
            end
            DONE: begin
                clear   = 1'b1;
                state_d = start_i ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef SOBEL_SCHED_TIMEOUT_EN
        wdog_d = '0;
        if ((state_q == WAIT_RD) || (state_q == WAIT_RES)) begin
            wdog_d = wdog_q + 8'd1;
            if (wdog_q == WDOG_LIMIT) begin
                state_d     = IDLE;
                err_d       = 1'b1;
                out_valid_d = 1'b0;
            end
        end
`endif

        if (reset_i) clear = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            gap_q       <= 1'b0;
            px_q        <= '0;
            out_px_q    <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef SOBEL_SCHED_TIMEOUT_EN
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            px_q        <= px_d;
            out_px_q    <= out_px_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
`ifdef SOBEL_SCHED_TIMEOUT_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

    assign bus.mem_rd_req_o  = (state_q == ISSUE);
    assign bus.mem_rd_addr_o = (state_q == ISSUE) ? addr : '0;
    assign bus.start_sobel_o = (state_q == ISSUE) || (state_q == WAIT_RD) ||
                               (state_q == PUSH)  || (state_q == WAIT_RES);
    assign bus.px_rdy_o      = (state_q == PUSH);
    assign bus.px_o          = px_q;
    assign out_valid_o       = out_valid_q;
    assign out_px_o          = out_px_q;
    assign busy_o            = (state_q != IDLE);
    assign frame_done_o      = (state_q == DONE);
    assign err_o             = err_q;

endmodule
